// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: FSM state encoding, default operand width
// and the bit-counter sizing helper used by the serial arithmetic blocks.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int unsigned DEFAULT_WIDTH = 8;

    // Counter width for a WIDTH-step sequence, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/serial_fa_cell.sv
// Combinational 1-bit full adder; the only arithmetic cell of the serial adder.
module serial_fa_cell (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (x & ci) | (y & ci);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder with start/busy/done handshake.
// Optional subtract mode and signed-overflow flag under `SERIAL_ADDER_SUB_EN.
module serial_adder
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_SUB_EN
    output logic             ovf,
`endif
    output logic             cout
);

    localparam int unsigned CW = cnt_width(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             accept;
    logic             fa_s, fa_co;
`ifdef SERIAL_ADDER_SUB_EN
    logic             ovf_q, ovf_d;
`endif

    serial_fa_cell u_fa (
        .x  (a_q[0]),
        .y  (b_q[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    // Next-state, datapath and output decode.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        accept  = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        ovf_d   = ovf_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (start) accept = 1'b1;
            end
            RUN: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = fa_co;
                sum_d   = WIDTH'({fa_s, sum_q} >> 1);
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                    cout_d  = fa_co;
`ifdef SERIAL_ADDER_SUB_EN
                    // carry into the MSB is carry_q on the final bit
                    ovf_d   = carry_q ^ fa_co;
`endif
                end
            end
            DONE: begin
                if (start) accept = 1'b1;
                else       state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            state_d = RUN;
            a_d     = a;
            cnt_d   = '0;
`ifdef SERIAL_ADDER_SUB_EN
            b_d     = sub ? ~b : b;
            carry_d = sub ? 1'b1 : cin;
`else
            b_d     = b;
            carry_d = cin;
`endif
        end

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef SERIAL_ADDER_SUB_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf_q <= 1'b0;
        else        ovf_q <= ovf_d;
    end

    assign ovf = ovf_q;
`endif

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder at WIDTH=4 and WIDTH=8 with an expected-result queue.
// Define SERIAL_ADDER_SUB_EN to also exercise subtract and overflow.
module tb_serial_adder;

    typedef struct {
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } exp_t;

    logic       clk;
    logic       rst_n;

    logic       start4, cin4, busy4, done4, cout4, ovf4;
    logic [3:0] a4, b4, sum4;

    logic       start8, cin8, sub8, busy8, done8, cout8, ovf8;
    logic [7:0] a8, b8, sum8;

    int   n_vec;
    int   n_err;
    exp_t q8[$];

    serial_adder #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start4),
        .a     (a4),
        .b     (b4),
        .cin   (cin4),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (1'b0),
`endif
        .busy  (busy4),
        .done  (done4),
        .sum   (sum4),
`ifdef SERIAL_ADDER_SUB_EN
        .ovf   (ovf4),
`endif
        .cout  (cout4)
    );

    serial_adder #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .cin   (cin8),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub8),
`endif
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
`ifdef SERIAL_ADDER_SUB_EN
        .ovf   (ovf8),
`endif
        .cout  (cout8)
    );

`ifndef SERIAL_ADDER_SUB_EN
    assign ovf4 = 1'b0;
    assign ovf8 = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: a + b' + c with b' = ~b for subtract; overflow from operand/result signs.
    function automatic exp_t model8(input logic [7:0] x, input logic [7:0] y,
                                    input logic ci, input logic s);
        exp_t       e;
        logic [7:0] yy;
        logic [8:0] full;
        yy     = s ? ~y : y;
        full   = {1'b0, x} + {1'b0, yy} + {8'd0, (s ? 1'b1 : ci)};
        e.sum  = full[7:0];
        e.cout = full[8];
        e.ovf  = (x[7] == yy[7]) && (full[7] != x[7]);
        return e;
    endfunction

    // Step until done8 (bounded), then pop and compare the oldest expectation.
    task automatic wait_done8(input string tag, output int cycles);
        exp_t e;
        cycles = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            cycles++;
            if (done8) break;
        end
        chk({tag, "_done"}, 32'(done8), 32'd1);
        if (done8) begin
            chk({tag, "_q"}, 32'(q8.size() > 0), 32'd1);
            if (q8.size() > 0) begin
                e = q8.pop_front();
                chk({tag, "_sum"}, 32'(sum8), 32'(e.sum));
                chk({tag, "_cout"}, 32'(cout8), 32'(e.cout));
`ifdef SERIAL_ADDER_SUB_EN
                chk({tag, "_ovf"}, 32'(ovf8), 32'(e.ovf));
`endif
            end
        end
    endtask

    task automatic run8(input string tag, input logic [7:0] x, input logic [7:0] y,
                        input logic ci, input logic s);
        int c;
        a8 = x; b8 = y; cin8 = ci; sub8 = s; start8 = 1'b1;
        q8.push_back(model8(x, y, ci, s));
        step();
        start8 = 1'b0;
        a8 = 8'hxx; b8 = 8'hxx; cin8 = 1'bx; sub8 = 1'bx;
        chk({tag, "_busy"}, 32'(busy8), 32'd1);
        wait_done8(tag, c);
        chk({tag, "_lat"}, 32'(c), 32'd8);
        sub8 = 1'b0; cin8 = 1'b0;
    endtask

    initial begin
        int   c1, c2, nd;
        logic [7:0] rx, ry;

        n_vec = 0; n_err = 0;
        rst_n = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0;

        // Reset with clock running, then idle
        repeat (3) step();
        chk("rst_busy4", 32'(busy4), 32'd0);
        chk("rst_done4", 32'(done4), 32'd0);
        chk("rst_sum4",  32'(sum4),  32'd0);
        chk("rst_cout4", 32'(cout4), 32'd0);
        chk("rst_busy8", 32'(busy8), 32'd0);
        chk("rst_done8", 32'(done8), 32'd0);
        chk("rst_sum8",  32'(sum8),  32'd0);
        chk("rst_cout8", 32'(cout8), 32'd0);
        chk("rst_ovf8",  32'(ovf8),  32'd0);
        rst_n = 1'b1;
        repeat (5) step();
        chk("idle_out4", 32'({busy4, done4, sum4, cout4}), 32'd0);
        chk("idle_out8", 32'({busy8, done8, sum8, cout8}), 32'd0);

        // WIDTH=4: 9 + 7 + 0 = 16 -> sum 0, cout 1
        a4 = 4'd9; b4 = 4'd7; cin4 = 1'b0; start4 = 1'b1;
        step();
        start4 = 1'b0; a4 = 4'hx; b4 = 4'hx;
        for (int i = 0; i < 4; i++) begin
            chk("w4_busy", 32'(busy4), 32'd1);
            chk("w4_nodone", 32'(done4), 32'd0);
            if (i < 3) step();
        end
        step();
        chk("w4_done", 32'(done4), 32'd1);
        chk("w4_busy_off", 32'(busy4), 32'd0);
        chk("w4_sum", 32'(sum4), 32'd0);
        chk("w4_cout", 32'(cout4), 32'd1);
        nd = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (done4) nd++;
            chk("w4_hold", 32'({sum4, cout4}), 32'h01);
        end
        chk("w4_single_pulse", 32'(nd), 32'd0);

        // WIDTH=8 boundary: FF + 00 + 1 wraps to 0 with carry
        run8("ff_cin", 8'hFF, 8'h00, 1'b1, 1'b0);

        // Back-to-back with start held through done, then a mid-RUN start pulse
        a8 = 8'd3; b8 = 8'd4; cin8 = 1'b0; start8 = 1'b1;
        q8.push_back(model8(8'd3, 8'd4, 1'b0, 1'b0));
        step();
        a8 = 8'd200; b8 = 8'd100;
        q8.push_back(model8(8'd200, 8'd100, 1'b0, 1'b0));
        wait_done8("b2b_1", c1);
        chk("b2b_1_lat", 32'(c1), 32'd8);
        step();
        start8 = 1'b0; a8 = 8'hxx; b8 = 8'hxx;
        chk("b2b_rerun_busy", 32'(busy8), 32'd1);
        repeat (3) step();
        a8 = 8'd1; b8 = 8'd1; start8 = 1'b1;
        step();
        start8 = 1'b0;
        wait_done8("b2b_2", c2);
        chk("b2b_spacing", 32'(5 + c2), 32'd9);
        nd = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (done8 || busy8) nd++;
        end
        chk("b2b_no_extra", 32'(nd), 32'd0);
        chk("b2b_hold", 32'({sum8, cout8}), 32'({8'd44, 1'b1}));

        // Reset during RUN cycle 3 discards the partial result
        a8 = 8'd100; b8 = 8'd100; start8 = 1'b1;
        step();
        start8 = 1'b0;
        repeat (2) step();
        chk("mid_busy", 32'(busy8), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out", 32'({busy8, done8, sum8, cout8}), 32'd0);
        step();
        rst_n = 1'b1;
        nd = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (done8 || busy8) nd++;
        end
        chk("mid_rst_quiet", 32'(nd), 32'd0);
        run8("after_rst", 8'd5, 8'd6, 1'b0, 1'b0);

        // A few random additions
        for (int i = 0; i < 6; i++) begin
            rx = 8'($urandom);
            ry = 8'($urandom);
            run8("rand", rx, ry, 1'($urandom_range(1)), 1'b0);
        end

`ifdef SERIAL_ADDER_SUB_EN
        run8("sub_ovf", 8'h80, 8'h01, 1'b0, 1'b1);
        chk("sub_ovf_val", 32'({sum8, ovf8}), 32'({8'h7F, 1'b1}));
        run8("sub_pos", 8'd5, 8'd3, 1'b1, 1'b1);
        chk("sub_pos_val", 32'({sum8, ovf8, cout8}), 32'({8'd2, 1'b0, 1'b1}));
        run8("add_ovf", 8'h7F, 8'h01, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            rx = 8'($urandom);
            ry = 8'($urandom);
            run8("rand_sub", rx, ry, 1'b0, 1'b1);
        end
`endif

        chk("queue_empty", 32'(q8.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
